// File: rtl/counter_cmd_if.sv
// ============================================================================
// Module      : counter_cmd_if
// Description : Command valid/ready channel into counter_cmd_driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_cmd_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_stop_at_limit;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps, cmd_stop_at_limit,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps, cmd_stop_at_limit,
        output cmd_ready
    );
endinterface

`default_nettype wire

// File: rtl/counter_cmd_driver.sv
// ============================================================================
// Module      : counter_cmd_driver
// Description : Executes LOAD/UP/DOWN/HOLD commands against an up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_cmd_driver #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    counter_cmd_if.slave           cmd,
    output logic                   load_n,
    output logic                   ce,
    output logic                   up_down,
    output logic [WIDTH-1:0]       data_load,
    input  wire logic              zero,
    input  wire logic              max_count,
    output logic                   busy,
    output logic                   done,
    output logic                   hit_limit,
    output logic [STEP_W-1:0]      steps_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] C_OP_LOAD = 2'b00;
    localparam logic [1:0] C_OP_UP   = 2'b01;
    localparam logic [1:0] C_OP_DOWN = 2'b10;
    localparam logic [1:0] C_OP_HOLD = 2'b11;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [STEP_W-1:0] r_remaining;
    logic              r_stop;
    logic [WIDTH-1:0]  r_data_load;
    logic [STEP_W-1:0] r_steps_done;
    logic              r_hit_pending;

    logic              w_accept;
    logic              w_limit_now;

    assign w_accept    = cmd.cmd_valid && (r_state == S_IDLE);
    // Flags are used combinationally so ce drops in the very cycle the limit shows.
    assign w_limit_now = r_stop && (((r_op == C_OP_UP) && max_count) ||
                                    ((r_op == C_OP_DOWN) && zero));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd.cmd_op == C_OP_LOAD)
                        w_next = S_LOAD;
                    else if (cmd.cmd_steps == '0)
                        w_next = S_DONE;
                    else
                        w_next = S_RUN;
                end
            end
            S_LOAD:  w_next = S_DONE;
            S_RUN: begin
                if (w_limit_now || (r_remaining == STEP_W'(1)))
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= C_OP_LOAD;
            r_remaining   <= '0;
            r_stop        <= 1'b0;
            r_data_load   <= '0;
            r_steps_done  <= '0;
            r_hit_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op          <= cmd.cmd_op;
                r_remaining   <= cmd.cmd_steps;
                r_stop        <= cmd.cmd_stop_at_limit;
                r_steps_done  <= '0;
                r_hit_pending <= 1'b0;
                if (cmd.cmd_op == C_OP_LOAD)
                    r_data_load <= cmd.cmd_data;
            end else if (r_state == S_RUN) begin
                if (w_limit_now) begin
                    r_hit_pending <= 1'b1;
                end else begin
                    r_remaining <= r_remaining - STEP_W'(1);
                    if (r_steps_done != '1)
                        r_steps_done <= r_steps_done + STEP_W'(1);
                end
            end
        end
    end

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign load_n        = (r_state != S_LOAD);
    assign ce            = (r_state == S_RUN) && (r_op != C_OP_HOLD) && !w_limit_now;
    assign up_down       = (r_state == S_RUN) && (r_op == C_OP_UP);
    assign data_load     = r_data_load;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign hit_limit     = (r_state == S_DONE) && r_hit_pending;
    assign steps_done    = r_steps_done;

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_driver.sv
// ============================================================================
// Module      : tb_counter_cmd_driver
// Description : Directed self-checking bench with a behavioural 4-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_cmd_driver;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_n, ce, up_down, busy, done, hit_limit;
    logic [WIDTH-1:0]  data_load;
    logic [STEP_W-1:0] steps_done;
    logic              zero, max_count;
    logic [WIDTH-1:0]  cnt = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // Results gathered by collect()
    int   n_ce, n_ld, done_idx, busy_low, first_ce;
    logic hit_seen, ud_bad;

    counter_cmd_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) cmd_if ();

    counter_cmd_driver #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if.slave),
        .load_n     (load_n),
        .ce         (ce),
        .up_down    (up_down),
        .data_load  (data_load),
        .zero       (zero),
        .max_count  (max_count),
        .busy       (busy),
        .done       (done),
        .hit_limit  (hit_limit),
        .steps_done (steps_done)
    );

    always #5 clk = ~clk;

    // Reference model of the loadable up/down counter being driven
    always @(posedge clk) begin
        if (!load_n)
            cnt <= data_load;
        else if (ce)
            cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign zero      = (cnt == 4'h0);
    assign max_count = (cnt == 4'hF);

    task automatic issue(input logic [1:0] op, input logic [3:0] d,
                         input logic [7:0] s, input logic stp);
        @(negedge clk);
        cmd_if.cmd_valid         = 1'b1;
        cmd_if.cmd_op            = op;
        cmd_if.cmd_data          = d;
        cmd_if.cmd_steps         = s;
        cmd_if.cmd_stop_at_limit = stp;
        for (int i = 0; i < 50 && !cmd_if.cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic collect();
        n_ce = 0; n_ld = 0; done_idx = 0; busy_low = 0; first_ce = 0;
        hit_seen = 1'b0; ud_bad = 1'b0;
        for (int idx = 1; idx <= 64; idx++) begin
            @(negedge clk);
            if (ce) begin
                n_ce++;
                if (first_ce == 0) first_ce = idx;
            end
            if (!load_n) n_ld++;
            if (!busy) busy_low++;
            if (done) begin
                done_idx = idx;
                hit_seen = hit_limit;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = OP_LOAD; cmd_if.cmd_data = '0;
        cmd_if.cmd_steps = '0;   cmd_if.cmd_stop_at_limit = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({load_n, ce, up_down, busy, done, hit_limit} !== 6'b100000)
            $display("FAIL reset_ctrl got %b want %b", {load_n, ce, up_down, busy, done, hit_limit}, 6'b100000);
        else n_pass++;
        n_checks++; if ({data_load, steps_done} !== 12'h000)
            $display("FAIL reset_data got %h want %h", {data_load, steps_done}, 12'h000);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_if.cmd_ready !== 1'b1)
            $display("FAIL reset_ready got %b want 1", cmd_if.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_load();
        issue(OP_LOAD, 4'hA, 8'd7, 1'b0);
        collect();
        n_checks++; if (n_ld !== 1) $display("FAIL load_n_cycles got %0d want 1", n_ld); else n_pass++;
        n_checks++; if (done_idx !== 2) $display("FAIL load_latency got %0d want 2", done_idx); else n_pass++;
        n_checks++; if (n_ce !== 0) $display("FAIL load_ce got %0d want 0", n_ce); else n_pass++;
        n_checks++; if (cnt !== 4'hA) $display("FAIL load_count got %h want a", cnt); else n_pass++;
        n_checks++; if (steps_done !== 8'd0) $display("FAIL load_steps got %0d want 0", steps_done); else n_pass++;
        n_checks++; if (data_load !== 4'hA) $display("FAIL load_data got %h want a", data_load); else n_pass++;
    endtask

    task automatic test_up();
        issue(OP_UP, 4'h0, 8'd3, 1'b0);
        fork
            collect();
            begin
                for (int i = 0; i < 64 && !done; i++) begin
                    @(negedge clk);
                    if (ce && !up_down) ud_bad = 1'b1;
                end
            end
        join
        n_checks++; if (n_ce !== 3) $display("FAIL up_ce got %0d want 3", n_ce); else n_pass++;
        n_checks++; if (first_ce !== 1) $display("FAIL up_first_ce got %0d want 1", first_ce); else n_pass++;
        n_checks++; if (done_idx !== 4) $display("FAIL up_latency got %0d want 4", done_idx); else n_pass++;
        n_checks++; if (ud_bad !== 1'b0) $display("FAIL up_dir got %b want 0", ud_bad); else n_pass++;
        n_checks++; if (cnt !== 4'hD) $display("FAIL up_count got %h want d", cnt); else n_pass++;
        n_checks++; if (steps_done !== 8'd3) $display("FAIL up_steps got %0d want 3", steps_done); else n_pass++;
        n_checks++; if (hit_seen !== 1'b0) $display("FAIL up_hit got %b want 0", hit_seen); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done, cmd_if.cmd_ready} !== 2'b01)
            $display("FAIL up_done_pulse got %b want 01", {done, cmd_if.cmd_ready});
        else n_pass++;
    endtask

    task automatic test_up_limit();
        issue(OP_UP, 4'h0, 8'd10, 1'b1);
        collect();
        n_checks++; if (n_ce !== 2) $display("FAIL lim_ce got %0d want 2", n_ce); else n_pass++;
        n_checks++; if (cnt !== 4'hF) $display("FAIL lim_count got %h want f", cnt); else n_pass++;
        n_checks++; if (hit_seen !== 1'b1) $display("FAIL lim_hit got %b want 1", hit_seen); else n_pass++;
        n_checks++; if (steps_done !== 8'd2) $display("FAIL lim_steps got %0d want 2", steps_done); else n_pass++;
        n_checks++; if (done_idx !== 4) $display("FAIL lim_latency got %0d want 4", done_idx); else n_pass++;
        issue(OP_LOAD, 4'hD, 8'd0, 1'b0);
        collect();
        issue(OP_UP, 4'h0, 8'd10, 1'b0);
        collect();
        n_checks++; if (cnt !== 4'h7) $display("FAIL wrap_count got %h want 7", cnt); else n_pass++;
        n_checks++; if (steps_done !== 8'd10) $display("FAIL wrap_steps got %0d want 10", steps_done); else n_pass++;
        n_checks++; if (hit_seen !== 1'b0) $display("FAIL wrap_hit got %b want 0", hit_seen); else n_pass++;
    endtask

    task automatic test_down();
        issue(OP_DOWN, 4'h0, 8'd0, 1'b0);
        collect();
        n_checks++; if (n_ce !== 0) $display("FAIL down0_ce got %0d want 0", n_ce); else n_pass++;
        n_checks++; if (done_idx !== 1) $display("FAIL down0_latency got %0d want 1", done_idx); else n_pass++;
        issue(OP_LOAD, 4'h2, 8'd0, 1'b0);
        collect();
        issue(OP_DOWN, 4'h0, 8'd5, 1'b1);
        collect();
        n_checks++; if (n_ce !== 2) $display("FAIL down_ce got %0d want 2", n_ce); else n_pass++;
        n_checks++; if (cnt !== 4'h0) $display("FAIL down_count got %h want 0", cnt); else n_pass++;
        n_checks++; if (hit_seen !== 1'b1) $display("FAIL down_hit got %b want 1", hit_seen); else n_pass++;
        n_checks++; if (steps_done !== 8'd2) $display("FAIL down_steps got %0d want 2", steps_done); else n_pass++;
    endtask

    task automatic test_hold();
        issue(OP_HOLD, 4'h0, 8'd4, 1'b0);
        collect();
        n_checks++; if ({n_ce, n_ld} !== {32'd0, 32'd0})
            $display("FAIL hold_pins got ce=%0d ld=%0d want 0 0", n_ce, n_ld);
        else n_pass++;
        n_checks++; if (busy_low !== 0) $display("FAIL hold_busy got %0d idle cycles want 0", busy_low); else n_pass++;
        n_checks++; if (done_idx !== 5) $display("FAIL hold_latency got %0d want 5", done_idx); else n_pass++;
        n_checks++; if (cnt !== 4'h0) $display("FAIL hold_count got %h want 0", cnt); else n_pass++;
        n_checks++; if (steps_done !== 8'd4) $display("FAIL hold_steps got %0d want 4", steps_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ready_idx;
        ready_idx = 0;
        issue(OP_HOLD, 4'h0, 8'd2, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_UP;
        cmd_if.cmd_steps = 8'd1;
        // HOLD 2: RUN idx1-2, DONE idx3, IDLE idx4 accepts UP, RUN idx5, DONE idx6
        n_ce = 0; first_ce = 0; done_idx = 0;
        for (int idx = 1; idx <= 20; idx++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready && ready_idx == 0) ready_idx = idx;
            if (ce) begin
                n_ce++;
                if (first_ce == 0) first_ce = idx;
            end
            if (idx == 5) cmd_if.cmd_valid = 1'b0;
            if (done && idx > 3) begin
                done_idx = idx;
                break;
            end
        end
        cmd_if.cmd_valid = 1'b0;
        n_checks++; if (ready_idx !== 4) $display("FAIL b2b_ready got %0d want 4", ready_idx); else n_pass++;
        n_checks++; if (first_ce !== 5) $display("FAIL b2b_first_ce got %0d want 5", first_ce); else n_pass++;
        n_checks++; if (n_ce !== 1) $display("FAIL b2b_ce got %0d want 1", n_ce); else n_pass++;
        n_checks++; if (done_idx !== 6) $display("FAIL b2b_done got %0d want 6", done_idx); else n_pass++;
        n_checks++; if (cnt !== 4'h1) $display("FAIL b2b_count got %h want 1", cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        issue(OP_LOAD, 4'h5, 8'd0, 1'b0);
        collect();
        issue(OP_UP, 4'h0, 8'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if ({ce, load_n, busy, done} !== 4'b0100)
            $display("FAIL rstmid_pins got %b want 0100", {ce, load_n, busy, done});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst = 1'b0;
        #1;
        n_checks++; if (done_cnt !== 0) $display("FAIL rstmid_done got %0d want 0", done_cnt); else n_pass++;
        n_checks++; if ({cmd_if.cmd_ready, steps_done} !== {1'b1, 8'd0})
            $display("FAIL rstmid_idle got %b/%0d want 1/0", cmd_if.cmd_ready, steps_done);
        else n_pass++;
        n_checks++; if (cnt !== 4'h6) $display("FAIL rstmid_count got %h want 6", cnt); else n_pass++;
        issue(OP_LOAD, 4'h3, 8'd0, 1'b0);
        collect();
        n_checks++; if (done_idx !== 2) $display("FAIL rstmid_load_lat got %0d want 2", done_idx); else n_pass++;
        n_checks++; if (cnt !== 4'h3) $display("FAIL rstmid_load_count got %h want 3", cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_up();
        test_up_limit();
        test_down();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_cmd_driver.md
Name: counter_cmd_driver

Overview:
Command-level initiator for the up/down loadable counter. Accepts one command at a time over a valid/ready handshake. Each command is LOAD, UP, DOWN or HOLD with a step count. The block drives the counter's load_n, ce, up_down and data_load pins. It reads the counter's zero and max_count flags back so it can optionally stop before a wrap, and it reports completion.

Parameters:
WIDTH, 4, counter data width; must match the counter instance.
STEP_W, 8, width of the step count and of the steps_done counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  00=LOAD, 01=UP, 10=DOWN, 11=HOLD
cmd_data  input  WIDTH  load value; used for LOAD only
cmd_steps  input  STEP_W  cycles to run for UP/DOWN/HOLD; ignored for LOAD
cmd_stop_at_limit  input  1  for UP, stop when max_count=1; for DOWN, stop when zero=1
load_n  output  1  counter load strobe, active low
ce  output  1  counter count enable
up_down  output  1  counter direction, 1=up
data_load  output  WIDTH  counter load value
zero  input  1  counter flag, count_out==0
max_count  input  1  counter flag, count_out=={WIDTH{1'b1}}
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at command completion
hit_limit  output  1  one-cycle pulse, coincident with done, when a run ended on a limit
steps_done  output  STEP_W  ce-active (or hold) cycles executed by the last command; held until next accept

Behaviour:
- Reset values (applied immediately on rst=1):
  - state=IDLE, load_n=1, ce=0, up_down=0, data_load=0.
  - done=0, hit_limit=0, steps_done=0, busy=0.
  - Latched command cleared.
- Reset mid-operation: command aborted, no done pulse, outputs at reset values while rst=1. After release: IDLE, cmd_ready=1.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - Accept on clk edge with cmd_valid & cmd_ready. Latch op, data, steps, stop_at_limit. Clear steps_done.
  - LOAD goes to LOAD. UP, DOWN or HOLD with steps>0 goes to RUN. steps==0 goes to DONE.
- LOAD: lasts exactly 1 cycle.
  - load_n=0, data_load=latched data, ce=0.
  - Next state DONE.
  - The counter captures the value at the edge that leaves LOAD.
- RUN:
  - remaining = latched steps, decremented each cycle. up_down=1 for UP, else 0.
  - limit_now = stop & ((UP & max_count) | (DOWN & zero)); combinational from the counter flags.
  - ce = (op!=HOLD) & !limit_now. Combinational gating ensures the counter never wraps when stop is set.
  - If limit_now: go to DONE, set hit_limit_pending, no increment of steps_done.
  - Otherwise: steps_done+1. Remaining reaching 0 goes to DONE.
  - HOLD drives ce=0, load_n=1 for `steps` cycles and counts them in steps_done.
- DONE: lasts 1 cycle.
  - done=1, hit_limit=pending, cmd_ready=0, ce=0, load_n=1.
  - Next state IDLE.
- data_load holds its last value outside LOAD. load_n=1 in all states except LOAD.
- cmd_valid while not in IDLE is ignored. The command is not consumed, and the source must hold it until ready.
- Latency:
  - LOAD accepted at edge N: done is high in the cycle after edge N+1.
  - UP/DOWN/HOLD with k steps and no limit: ce is high in cycles N..N+k-1, done is high in cycle N+k.
  - steps==0: done in the cycle after accept.
- Back-to-back: the minimum command period is 3 cycles for LOAD (accept, LOAD, DONE, then IDLE).
- The step counter saturates at its width. steps_done can never exceed cmd_steps.
- Stop is checked in RUN only, never in LOAD. Simultaneous zero and max_count is impossible for WIDTH≥1.

Test Plan:
- Reset, then LOAD cmd_data=4'hA -> load_n=0 for exactly 1 cycle with data_load=A; done 1 cycle later; counter reads 4'hA; steps_done=0.
- UP steps=3, stop=0, from count A -> ce=1, up_down=1 for 3 consecutive cycles; count=4'hD; done once; steps_done=3; hit_limit=0.
- UP steps=10 from D:
  - stop=1 -> ce high 2 cycles, count=4'hF, hit_limit=1 with done, steps_done=2.
  - Repeat from D with stop=0 -> count wraps to 4'h7, steps_done=10.
- DOWN steps=0 -> ce never asserted, done one cycle after accept. Then DOWN steps=5, stop=1, from count 2 -> ce 2 cycles, count=0, hit_limit=1, steps_done=2.
- HOLD steps=4 -> ce=0, load_n=1 for 4 cycles, count unchanged, busy=1 throughout, steps_done=4. cmd_valid held during busy is accepted only on return to IDLE.
- UP steps=5 with rst pulsed during the 2nd RUN cycle -> ce=0, load_n=1 immediately; no done; after release cmd_ready=1, steps_done=0; the next LOAD 4'h3 works normally.
